control_unit: RTL and testbench

Hardwired control sequencer for the datapath. It fetches each instruction, decodes the opcode in the instruction register, and steps through states T0..T7 one per clock. In each state it drives the datapath strobes itself, which the datapath benches currently generate by hand. It sits directly upstream of `datapath` and connects port-for-port to its control inputs.

---
 rtl/control_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_control_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch, decode ir[31:27], step T0..T7 driving datapath strobes.
// Optional mul/div sequencing is enabled by defining CU_MULDIV_EN.
module control_unit #(
  parameter int unsigned OPW = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        run,
  output logic        dp_clr,
  output logic        illegal_op,
  output logic        read,
  output logic        write,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        Cout,
  output logic        IN_Portout,
  output logic        LOout,
  output logic        HIout,
  output logic        MARIn,
  output logic        PCIn,
  output logic        MDRIn,
  output logic        IRIn,
  output logic        YIn,
  output logic        IncPC,
  output logic        HiIn,
  output logic        LoIn,
  output logic        CIn,
  output logic        InIn,
  output logic        OutIn,
  output logic        ZIn,
  output logic        CONIn,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        RIn,
  output logic        Rout,
  output logic        BAout,
  output logic        add,
  output logic        subtract,
  output logic        multiply,
  output logic        divide,
  output logic        andSignal,
  output logic        orSignal
);

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10101);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b10111);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11010);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_STOPPED
  } state_t;

  state_t state, state_nxt;
  logic [OPW-1:0] op;
  logic unused_ir;
  logic is_r, is_i, is_md, is_ld, is_ldi, is_st, is_one, is_nop, is_halt, is_ill;
  state_t boundary;

  assign op        = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];
  assign boundary  = stop ? S_STOPPED : S_T0;

  // Opcode class decode
  always_comb begin
    is_r = 1'b0; is_i = 1'b0; is_md = 1'b0; is_ld = 1'b0; is_ldi = 1'b0;
    is_st = 1'b0; is_one = 1'b0; is_nop = 1'b0; is_halt = 1'b0; is_ill = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR:             is_r    = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:                  is_i    = 1'b1;
`ifdef CU_MULDIV_EN
      OP_MUL, OP_DIV:                            is_md   = 1'b1;
`endif
      OP_LD:                                     is_ld   = 1'b1;
      OP_LDI:                                    is_ldi  = 1'b1;
      OP_ST:                                     is_st   = 1'b1;
      OP_IN, OP_OUT, OP_MFHI, OP_MFLO:           is_one  = 1'b1;
      OP_NOP:                                    is_nop  = 1'b1;
      OP_HALT:                                   is_halt = 1'b1;
      default:                                   is_ill  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_RESET;
    else      state <= state_nxt;
  end

  // Next state and Moore strobe decode
  always_comb begin
    state_nxt  = state;
    run        = 1'b1;
    dp_clr     = 1'b0;
    illegal_op = 1'b0;
    read = 1'b0; write = 1'b0; PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    MDRout = 1'b0; Cout = 1'b0; IN_Portout = 1'b0; LOout = 1'b0; HIout = 1'b0;
    MARIn = 1'b0; PCIn = 1'b0; MDRIn = 1'b0; IRIn = 1'b0; YIn = 1'b0;
    IncPC = 1'b0; HiIn = 1'b0; LoIn = 1'b0; CIn = 1'b0; InIn = 1'b0;
    OutIn = 1'b0; ZIn = 1'b0; CONIn = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; RIn = 1'b0; Rout = 1'b0; BAout = 1'b0; add = 1'b0;
    subtract = 1'b0; multiply = 1'b0; divide = 1'b0; andSignal = 1'b0; orSignal = 1'b0;

    case (state)
      S_RESET: begin
        dp_clr    = 1'b1;
        state_nxt = S_T0;
      end
      S_T0: begin
        PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1; PCIn = 1'b1; read = 1'b1; MDRIn = 1'b1;
        state_nxt = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRIn = 1'b1;
        if (is_nop)       state_nxt = boundary;
        else if (is_halt) state_nxt = S_HALT;
        else              state_nxt = S_T3;
      end
      S_T3: begin
        state_nxt = S_T4;
        if (is_r || is_i) begin
          Grb = 1'b1; Rout = 1'b1; YIn = 1'b1;
        end else if (is_md) begin
          Gra = 1'b1; Rout = 1'b1; YIn = 1'b1;
        end else if (is_ld || is_ldi || is_st) begin
          Grb = 1'b1; BAout = 1'b1; YIn = 1'b1;
        end else if (is_one) begin
          state_nxt = boundary;
          case (op)
            OP_MFHI: begin HIout = 1'b1;      Gra = 1'b1; RIn = 1'b1; end
            OP_MFLO: begin LOout = 1'b1;      Gra = 1'b1; RIn = 1'b1; end
            OP_IN:   begin IN_Portout = 1'b1; Gra = 1'b1; RIn = 1'b1; end
            default: begin Gra = 1'b1; Rout = 1'b1; OutIn = 1'b1; end
          endcase
        end else begin
          illegal_op = 1'b1;
          state_nxt  = boundary;
        end
      end
      S_T4: begin
        state_nxt = S_T5;
        ZIn = 1'b1;
        if (is_r) begin
          Grc = 1'b1; Rout = 1'b1;
        end else if (is_md) begin
          Grb = 1'b1; Rout = 1'b1;
        end else begin
          Cout = 1'b1;
        end
        case (op)
          OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: add       = 1'b1;
          OP_SUB:                               subtract  = 1'b1;
          OP_AND, OP_ANDI:                      andSignal = 1'b1;
          OP_OR, OP_ORI:                        orSignal  = 1'b1;
`ifdef CU_MULDIV_EN
          OP_MUL:                               multiply  = 1'b1;
          OP_DIV:                               divide    = 1'b1;
`endif
          default: ;
        endcase
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_md) begin
          LoIn = 1'b1;
          state_nxt = S_T6;
        end else if (is_ld || is_st) begin
          MARIn = 1'b1;
          state_nxt = S_T6;
        end else begin
          Gra = 1'b1; RIn = 1'b1;
          state_nxt = boundary;
        end
      end
      S_T6: begin
        if (is_md) begin
          Zhighout = 1'b1; HiIn = 1'b1;
          state_nxt = boundary;
        end else begin
          MDRIn = 1'b1;
          if (is_st) begin
            Gra = 1'b1; Rout = 1'b1;
          end else begin
            read = 1'b1;
          end
          state_nxt = S_T7;
        end
      end
      S_T7: begin
        if (is_st) begin
          write = 1'b1;
        end else begin
          MDRout = 1'b1; Gra = 1'b1; RIn = 1'b1;
        end
        state_nxt = boundary;
      end
      S_HALT: begin
        run = 1'b0;
      end
      S_STOPPED: begin
        run = 1'b0;
        if (!stop) state_nxt = S_T0;
      end
      default: state_nxt = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction stream
// checked cycle by cycle against a per-instruction micro-step model.
module tb_control_unit;

  localparam int I_READ = 0, I_WRITE = 1, I_PCOUT = 2, I_ZLO = 3, I_ZHI = 4, I_MDROUT = 5;
  localparam int I_COUT = 6, I_INP = 7, I_LOOUT = 8, I_HIOUT = 9, I_MARIN = 10, I_PCIN = 11;
  localparam int I_MDRIN = 12, I_IRIN = 13, I_YIN = 14, I_INCPC = 15, I_HIIN = 16, I_LOIN = 17;
  localparam int I_OUTIN = 20, I_ZIN = 21, I_GRA = 23, I_GRB = 24;
  localparam int I_GRC = 25, I_RIN = 26, I_ROUT = 27, I_BAOUT = 28, I_ADD = 29, I_SUB = 30;
  localparam int I_MUL = 31, I_DIV = 32, I_AND = 33, I_OR = 34, I_ILL = 35, I_RUN = 36, I_DPCLR = 37;

  typedef enum int {C_R, C_I, C_MD, C_LD, C_LDI, C_ST, C_ONE, C_NOP, C_HALT, C_ILL} cls_t;

  logic clk, clr, stop;
  logic [31:0] ir;
  logic run, dp_clr, illegal_op;
  logic read, write, PCout, Zlowout, Zhighout, MDRout, Cout, IN_Portout, LOout, HIout;
  logic MARIn, PCIn, MDRIn, IRIn, YIn, IncPC, HiIn, LoIn, CIn, InIn, OutIn, ZIn, CONIn;
  logic Gra, Grb, Grc, RIn, Rout, BAout, add, subtract, multiply, divide, andSignal, orSignal;
  logic [37:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop), .run(run), .dp_clr(dp_clr),
    .illegal_op(illegal_op), .read(read), .write(write), .PCout(PCout),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout), .Cout(Cout),
    .IN_Portout(IN_Portout), .LOout(LOout), .HIout(HIout), .MARIn(MARIn),
    .PCIn(PCIn), .MDRIn(MDRIn), .IRIn(IRIn), .YIn(YIn), .IncPC(IncPC),
    .HiIn(HiIn), .LoIn(LoIn), .CIn(CIn), .InIn(InIn), .OutIn(OutIn), .ZIn(ZIn),
    .CONIn(CONIn), .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn), .Rout(Rout),
    .BAout(BAout), .add(add), .subtract(subtract), .multiply(multiply),
    .divide(divide), .andSignal(andSignal), .orSignal(orSignal)
  );

  assign obs = {dp_clr, run, illegal_op, orSignal, andSignal, divide, multiply, subtract,
                add, BAout, Rout, RIn, Grc, Grb, Gra, CONIn, ZIn, OutIn, InIn, CIn, LoIn,
                HiIn, IncPC, YIn, IRIn, MDRIn, PCIn, MARIn, HIout, LOout, IN_Portout, Cout,
                MDRout, Zhighout, Zlowout, PCout, write, read};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] b(input int i);
    return 38'(1) << i;
  endfunction

  function automatic cls_t classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b01001, 5'b01010: return C_R;
      5'b01011, 5'b01100, 5'b01101:           return C_I;
`ifdef CU_MULDIV_EN
      5'b01110, 5'b01111:                     return C_MD;
`endif
      5'b00000: return C_LD;
      5'b00001: return C_LDI;
      5'b00010: return C_ST;
      5'b10101, 5'b10110, 5'b10111, 5'b11000: return C_ONE;
      5'b11001: return C_NOP;
      5'b11010: return C_HALT;
      default:  return C_ILL;
    endcase
  endfunction

  function automatic int len_of(input logic [4:0] op);
    case (classify(op))
      C_R, C_I, C_LDI: return 6;
      C_MD:            return 7;
      C_LD, C_ST:      return 8;
      C_ONE, C_ILL:    return 4;
      default:         return 3;
    endcase
  endfunction

  function automatic logic [37:0] alu_bit(input logic [4:0] op);
    case (op)
      5'b00011, 5'b01011: return b(I_ADD);
      5'b00100:           return b(I_SUB);
      5'b01001, 5'b01100: return b(I_AND);
      5'b01010, 5'b01101: return b(I_OR);
      5'b01110:           return b(I_MUL);
      default:            return b(I_DIV);
    endcase
  endfunction

  // Expected outputs in step k (0 = T0) of an instruction with opcode op
  function automatic logic [37:0] expv(input logic [4:0] op, input int k);
    cls_t c;
    logic [37:0] v;
    c = classify(op);
    v = b(I_RUN);
    if (k == 0) v = v | b(I_PCOUT) | b(I_MARIN) | b(I_INCPC) | b(I_ZIN);
    else if (k == 1) v = v | b(I_ZLO) | b(I_PCIN) | b(I_READ) | b(I_MDRIN);
    else if (k == 2) v = v | b(I_MDROUT) | b(I_IRIN);
    else if (k == 3) begin
      case (c)
        C_R, C_I:          v = v | b(I_GRB) | b(I_ROUT) | b(I_YIN);
        C_MD:              v = v | b(I_GRA) | b(I_ROUT) | b(I_YIN);
        C_LD, C_LDI, C_ST: v = v | b(I_GRB) | b(I_BAOUT) | b(I_YIN);
        C_ONE: begin
          if (op == 5'b10111)      v = v | b(I_HIOUT) | b(I_GRA) | b(I_RIN);
          else if (op == 5'b11000) v = v | b(I_LOOUT) | b(I_GRA) | b(I_RIN);
          else if (op == 5'b10101) v = v | b(I_INP) | b(I_GRA) | b(I_RIN);
          else                     v = v | b(I_GRA) | b(I_ROUT) | b(I_OUTIN);
        end
        default: v = v | b(I_ILL);
      endcase
    end else if (k == 4) begin
      case (c)
        C_R:    v = v | b(I_GRC) | b(I_ROUT) | b(I_ZIN) | alu_bit(op);
        C_I:    v = v | b(I_COUT) | b(I_ZIN) | alu_bit(op);
        C_MD:   v = v | b(I_GRB) | b(I_ROUT) | b(I_ZIN) | alu_bit(op);
        default: v = v | b(I_COUT) | b(I_ADD) | b(I_ZIN);
      endcase
    end else if (k == 5) begin
      case (c)
        C_MD:       v = v | b(I_ZLO) | b(I_LOIN);
        C_LD, C_ST: v = v | b(I_ZLO) | b(I_MARIN);
        default:    v = v | b(I_ZLO) | b(I_GRA) | b(I_RIN);
      endcase
    end else if (k == 6) begin
      case (c)
        C_MD:    v = v | b(I_ZHI) | b(I_HIIN);
        C_LD:    v = v | b(I_READ) | b(I_MDRIN);
        default: v = v | b(I_GRA) | b(I_ROUT) | b(I_MDRIN);
      endcase
    end else begin
      if (c == C_ST) v = v | b(I_WRITE);
      else           v = v | b(I_MDROUT) | b(I_GRA) | b(I_RIN);
    end
    return v;
  endfunction

  task automatic chk(input logic [37:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from T0; optional stop raise, clr abort, and STOPPED hold length
  task automatic run_instr(input logic [31:0] instr, input int stop_k, input int abort_k,
                           input int hold);
    logic [4:0] op;
    int len;
    op  = instr[31:27];
    len = len_of(op);
    for (int k = 0; k < len; k++) begin
      tick();
      if (k == 2) ir = instr;
      if (k == stop_k) stop = 1'b1;
      #1;
      chk(expv(op, k), $sformatf("op%02h_t%0d", op, k));
      if (k == abort_k) begin
        clr = 1'b0;
        #1;
        chk(b(I_DPCLR) | b(I_RUN), $sformatf("abort_op%02h_t%0d", op, k));
        return;
      end
    end
    if (stop_k >= 0) begin
      tick();
      #1;
      chk(38'(0), "stopped_entry");
      for (int h = 0; h < hold; h++) begin
        tick();
        #1;
        chk(38'(0), "stopped_hold");
      end
      stop = 1'b0;
    end
  endtask

  task automatic release_clr();
    tick();
    clr = 1'b1;
    #1;
    chk(b(I_DPCLR) | b(I_RUN), "release_dp_clr");
  endtask

  initial begin
    logic [31:0] instr;
    logic [4:0]  op;
    int          sk;
    clr  = 1'b0;
    stop = 1'b0;
    ir   = 32'h0;
    repeat (3) tick();
    #1;
    chk(b(I_DPCLR) | b(I_RUN), "reset_state");
    release_clr();

    run_instr(32'h6120_0053, -1, -1, 0);   // andi r2,r4,0x53
    run_instr(32'h0080_0065, -1, -1, 0);   // ld
    run_instr(32'hF800_0000, -1, -1, 0);   // illegal
    run_instr(32'hC800_0000, -1, -1, 0);   // nop
    run_instr(32'h7000_0000, -1, -1, 0);   // mul (illegal unless enabled)
    run_instr(32'h1822_0000, 4, -1, 2);    // add, stop raised in T4
    run_instr(32'h1000_0000, -1, -1, 0);   // st
    run_instr(32'h1822_0000, -1, 4, 0);    // add, clr pulled in T4
    release_clr();

    run_instr(32'hD000_0000, -1, -1, 0);   // halt
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      chk(38'(0), "halt_hold");
    end
    clr = 1'b0;
    #1;
    chk(b(I_DPCLR) | b(I_RUN), "halt_clr");
    release_clr();

    for (int n = 0; n < 300; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11010) op = 5'b11001;
      instr = {op, 27'($urandom)};
      sk = -1;
      if ($urandom_range(0, 7) == 0) sk = $urandom_range(0, len_of(op) - 1);
      run_instr(instr, sk, -1, $urandom_range(0, 2));
    end
    run_instr(32'h0000_0000, -1, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
